// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/LS memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int INST_ADDR_W     = 32;
    localparam int INST_DATA_W     = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int MAX_DSTREAK_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_LS   = 2'b10
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_prio_pick.sv
// Combinational IF/LS grant with LS priority, plus the LS win-streak counter
// that hands the next contested cycle to IF once the streak saturates.
module arb_prio_pick #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic ls_req,
    output logic if_gnt,
    output logic ls_gnt
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    logic [SW-1:0] streak_reg;
    logic [SW-1:0] streak_next;
    logic          if_turn;

    assign if_turn = if_req && (streak_reg == STREAK_MAX);
    assign ls_gnt  = ~rst & ls_req & ~if_turn;
    assign if_gnt  = ~rst & if_req & ~ls_gnt;

    always_comb begin
        streak_next = streak_reg;
        if (!if_req || if_gnt) begin
            streak_next = '0;
        end else if (ls_gnt && streak_reg != STREAK_MAX) begin
            streak_next = streak_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the IF and LS ports of the
// core: one access per cycle, one-cycle response latency, stall on refusal.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = INST_ADDR_W,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_sel,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              stall_req,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_t owner_reg;
    owner_t owner_next;

    arb_prio_pick #(
        .MAX_DSTREAK(MAX_DSTREAK)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .if_req (if_req),
        .ls_req (ls_req),
        .if_gnt (if_gnt),
        .ls_gnt (ls_gnt)
    );

    always_comb begin
        owner_next = OWN_NONE;
        if (ls_gnt) begin
            owner_next = OWN_LS;
        end else if (if_gnt) begin
            owner_next = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg <= OWN_NONE;
        end else begin
            owner_reg <= owner_next;
        end
    end

    // A response owed from before reset must not surface in the reset cycle itself.
    assign if_rvalid = ~rst & (owner_reg == OWN_IF);
    assign ls_rvalid = ~rst & (owner_reg == OWN_LS);
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

    assign stall_req = ~rst & ((if_req & ~if_gnt) | (ls_req & ~ls_gnt));
    assign mem_en    = if_gnt | ls_gnt;
    assign mem_we    = ls_gnt & ls_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (ls_gnt) begin
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Reads always enable every lane; LS writes use the requested byte enables.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sel
        assign mem_sel[gi] = ls_gnt ? (~ls_we | ls_sel[gi]) : if_gnt;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a cycle-level
// reference model with its own shadow memory.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [3:0]  ls_sel;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        stall_req, mem_en, mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_sel(ls_sel), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .stall_req(stall_req), .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        return 32'h1000_0000 + 32'(idx) * 32'h0103_0507;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] w;
        w = old_w;
        for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = new_w[8*b +: 8];
        return w;
    endfunction

    // Single-port synchronous memory; unwritten words read back their init pattern.
    bit [31:0]  env_mem [256];
    bit [255:0] env_written;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                env_mem[mem_addr[9:2]] <= merge(env_written[mem_addr[9:2]] ?
                    env_mem[mem_addr[9:2]] : init_word(int'(mem_addr[9:2])), mem_wdata, mem_sel);
                env_written[mem_addr[9:2]] <= 1'b1;
            end else begin
                mem_rdata <= env_written[mem_addr[9:2]] ?
                    env_mem[mem_addr[9:2]] : init_word(int'(mem_addr[9:2]));
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    int          streak_m = 0;
    logic        pend_if = 1'b0, pend_ls = 1'b0, pend_ls_rd = 1'b0;
    logic [31:0] pend_if_data, pend_ls_data;
    logic        last_ls, last_if;
    logic [5:0]  seq6;
    logic [4:0]  seq5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check comb outputs and responses mid-cycle, then advance the model.
    task automatic tick();
        logic        exp_ls, exp_if;
        logic [31:0] exp_addr;
        logic [3:0]  exp_sel;
        @(negedge clk);
        exp_ls   = !rst && ls_req && !(if_req && streak_m == MAXS);
        exp_if   = !rst && if_req && !exp_ls;
        exp_addr = exp_ls ? ls_addr : (exp_if ? if_addr : 32'h0);
        exp_sel  = exp_ls ? (ls_we ? ls_sel : 4'hF) : (exp_if ? 4'hF : 4'h0);
        chk("if_gnt", 32'(if_gnt), 32'(exp_if));
        chk("ls_gnt", 32'(ls_gnt), 32'(exp_ls));
        chk("stall_req", 32'(stall_req),
            32'(!rst && ((if_req && !exp_if) || (ls_req && !exp_ls))));
        chk("mem_en", 32'(mem_en), 32'(exp_if || exp_ls));
        chk("mem_we", 32'(mem_we), 32'(exp_ls && ls_we));
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_sel", 32'(mem_sel), 32'(exp_sel));
        if (exp_ls && ls_we) chk("mem_wdata", mem_wdata, ls_wdata);
        chk("if_rvalid", 32'(if_rvalid), 32'(pend_if && !rst));
        chk("ls_rvalid", 32'(ls_rvalid), 32'(pend_ls && !rst));
        if (pend_if && !rst) chk("if_rdata", if_rdata, pend_if_data);
        if (pend_ls && pend_ls_rd && !rst) chk("ls_rdata", ls_rdata, pend_ls_data);
        last_ls = ls_gnt;
        last_if = if_gnt;
        if (rst) begin
            streak_m = 0;
            pend_if  = 1'b0;
            pend_ls  = 1'b0;
        end else begin
            pend_if    = exp_if;
            pend_ls    = exp_ls;
            pend_ls_rd = !ls_we;
            if (exp_if) pend_if_data = ref_mem[if_addr[9:2]];
            if (exp_ls) begin
                if (ls_we) ref_mem[ls_addr[9:2]] = merge(ref_mem[ls_addr[9:2]], ls_wdata, ls_sel);
                else       pend_ls_data = ref_mem[ls_addr[9:2]];
            end
            if (!if_req || exp_if)                streak_m = 0;
            else if (exp_ls && streak_m < MAXS)   streak_m++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_sel = 4'h0;
        if_addr = 32'h0; ls_addr = 32'h40; ls_wdata = 32'h0;

        // Reset held with both ports requesting
        for (int i = 0; i < 3; i++) tick();
        $display("reset: 3 cycles with both requests, gnt=%b/%b", if_gnt, ls_gnt);
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        tick();

        // Instruction stream
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_addr = 32'(4 * i);
            tick();
            $display("if fetch addr=%h gnt=%b", if_addr, last_if);
        end
        if_req = 1'b0;
        tick();

        // LS full write, read back, byte write, read back
        ls_req = 1'b1; ls_we = 1'b1; ls_sel = 4'hF; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF;
        tick();
        ls_we = 1'b0;
        tick();
        chk("ls_rd_full", ls_rdata, 32'hDEADBEEF);
        $display("ls write/read 0x100 -> %h", ls_rdata);
        ls_we = 1'b1; ls_sel = 4'b0001; ls_wdata = 32'h000000AA;
        tick();
        ls_we = 1'b0;
        tick();
        chk("ls_rd_byte", ls_rdata, 32'hDEADBEAA);
        $display("ls byte write/read 0x100 -> %h", ls_rdata);
        ls_req = 1'b0;
        tick();

        // Contention: LS wins MAXS times, then IF gets one
        if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h20; ls_addr = 32'h104;
        for (int i = 0; i < 6; i++) begin
            tick();
            seq6[i] = last_ls;
        end
        chk("contend_seq", 32'(seq6), 32'(6'b101111));
        $display("contention ls_gnt sequence=%b", seq6);
        if_req = 1'b0; ls_req = 1'b0;
        tick();

        // Reset right after an LS read grant drops the response and clears the streak
        ls_req = 1'b1; ls_addr = 32'h100;
        tick();
        rst = 1'b1; ls_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        if_req = 1'b1; ls_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            seq5[i] = last_ls;
        end
        chk("post_rst_seq", 32'(seq5), 32'(5'b01111));
        $display("post-reset contention ls_gnt sequence=%b", seq5);
        if_req = 1'b0; ls_req = 1'b0;
        tick();

        // Withdrawn IF request after losing to LS
        if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h44;
        tick();
        if_req = 1'b0; ls_req = 1'b0;
        tick();
        tick();
        $display("withdrawn if request: if_rvalid=%b", if_rvalid);

        // Randomized traffic including occasional resets
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 39) == 0);
            if_req   = ($urandom_range(0, 3) != 0);
            ls_req   = ($urandom_range(0, 2) != 0);
            ls_we    = $urandom_range(0, 1) == 1;
            ls_sel   = 4'($urandom_range(0, 15));
            ls_wdata = $urandom;
            if_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            ls_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            tick();
            $display("rand %0d rst=%b if=%b/%b ls=%b/%b we=%b", n, rst, if_req, last_if,
                     ls_req, last_ls, ls_we);
        end
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
